// File: rtl/multi_clkdiv_pkg.sv
// multi_clkdiv_pkg: shared constants, channel config type and duty helper for multi_clkdiv
package multi_clkdiv_pkg;
  localparam int WIDTH_DEF = 16;
  localparam int CHANNELS_DEF = 4;
  localparam int MAX_WIDTH = 32;
  typedef struct packed {
    logic [WIDTH_DEF-1:0] n;
    logic [WIDTH_DEF-1:0] t;
  } channel_cfg_t;
  function automatic logic [MAX_WIDTH-1:0] half_period(input logic [MAX_WIDTH-1:0] n);
    return n >> 1;
  endfunction
endpackage

// File: rtl/clkdiv_channel.sv
// clkdiv_channel: one down-counting divider with double-buffered period and complementary ticks
// MULTI_CLKDIV_DUTY_EN selects a loadable phase0 threshold instead of N>>1
module clkdiv_channel
  import multi_clkdiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             act,
  input  logic             sync,
  input  logic             load,
  input  logic [WIDTH-1:0] period_in,
`ifdef MULTI_CLKDIV_DUTY_EN
  input  logic [WIDTH-1:0] duty_in,
`endif
  output logic             tick_phase0,
  output logic             tick_phase180,
  output logic             wrap
);
  logic [WIDTH-1:0] count, n_act, n_sh, thr;
  logic pend, wrap_ev, take, low;
`ifdef MULTI_CLKDIV_DUTY_EN
  logic [WIDTH-1:0] t_act, t_sh;
  assign thr = t_act;
`else
  assign thr = WIDTH'(half_period(MAX_WIDTH'(n_act)));
`endif
  assign wrap_ev = act && (count == '0 || sync);
  assign take = pend || load;
  assign low = count < thr;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      count <= '0;
      n_act <= '0;
      n_sh <= '0;
      pend <= 1'b0;
      tick_phase0 <= 1'b0;
      tick_phase180 <= 1'b0;
      wrap <= 1'b0;
`ifdef MULTI_CLKDIV_DUTY_EN
      t_act <= '0;
      t_sh <= '0;
`endif
    end else begin
      if (load) n_sh <= period_in;
      pend <= !wrap_ev && take;
      wrap <= wrap_ev;
`ifdef MULTI_CLKDIV_DUTY_EN
      if (load) t_sh <= duty_in;
      if (wrap_ev && take) t_act <= load ? duty_in : t_sh;
`endif
      if (wrap_ev) begin
        // a load in the same cycle as the boundary beats the older shadow value
        count <= take ? (load ? period_in : n_sh) : n_act;
        if (take) n_act <= load ? period_in : n_sh;
        tick_phase0 <= 1'b1;
        tick_phase180 <= 1'b0;
      end else if (act) begin
        count <= count - 1'b1;
        tick_phase0 <= low;
        tick_phase180 <= !low;
      end
    end
endmodule

// File: rtl/multi_clkdiv.sv
// multi_clkdiv: multi-channel programmable tick generator with global enable and sync
// MULTI_CLKDIV_DUTY_EN enables per-channel duty thresholds from duty_in
module multi_clkdiv
  import multi_clkdiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CHANNELS = CHANNELS_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [CHANNELS-1:0]       ch_en,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CHANNELS*WIDTH-1:0] period_in,
  input  logic [CHANNELS*WIDTH-1:0] duty_in,
  input  logic                      sync,
  output logic [CHANNELS-1:0]       tick_phase0,
  output logic [CHANNELS-1:0]       tick_phase180,
  output logic [CHANNELS-1:0]       wrap
);
`ifndef MULTI_CLKDIV_DUTY_EN
  logic unused_duty;
  assign unused_duty = ^duty_in;
`endif
  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    clkdiv_channel #(.WIDTH(WIDTH)) u_ch (
      .clk(clk),
      .rst(rst),
      .act(en && ch_en[k]),
      .sync(sync),
      .load(load[k]),
      .period_in(period_in[k*WIDTH +: WIDTH]),
`ifdef MULTI_CLKDIV_DUTY_EN
      .duty_in(duty_in[k*WIDTH +: WIDTH]),
`endif
      .tick_phase0(tick_phase0[k]),
      .tick_phase180(tick_phase180[k]),
      .wrap(wrap[k])
    );
  end
endmodule

// File: tb/tb_multi_clkdiv.sv
// tb_multi_clkdiv: scoreboard bench for multi_clkdiv (WIDTH=8, CHANNELS=2, duty macro off)
module tb_multi_clkdiv;
  localparam int W = 8;
  localparam int C = 2;
  logic clk = 1'b0, rst = 1'b0, en = 1'b0, sync = 1'b0;
  logic [C-1:0] ch_en = '0, load = '0;
  logic [C*W-1:0] period_in = '0, duty_in = '0;
  logic [C-1:0] tick_phase0, tick_phase180, wrap;
  typedef struct {
    logic [1:0] p0;
    logic [1:0] p180;
    logic [1:0] w;
  } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  bit [15:0] pat[C], npat[C];
  int len[C], nlen[C], idx[C];
  bit pend[C];
  logic [1:0] lp0, lp180;

  multi_clkdiv #(.WIDTH(W), .CHANNELS(C)) dut (
    .clk(clk), .rst(rst), .en(en), .ch_en(ch_en), .load(load),
    .period_in(period_in), .duty_in(duty_in), .sync(sync),
    .tick_phase0(tick_phase0), .tick_phase180(tick_phase180), .wrap(wrap)
  );

  always #5 clk = ~clk;

  // hand-derived phase0 per cycle of a period, bit i = i-th output after the wrap
  task automatic period_pat(input int n, output bit [15:0] p, output int l);
    case (n)
      0: begin p = 16'b1; l = 1; end
      3: begin p = 16'b0001; l = 4; end
      5: begin p = 16'b100001; l = 6; end
      7: begin p = 16'b11000001; l = 8; end
      default: begin p = 16'b1110000001; l = 10; end
    endcase
  endtask

  task automatic model_reset();
    for (int k = 0; k < C; k++) begin
      pat[k] = 16'b1; len[k] = 1; idx[k] = 0; pend[k] = 1'b0;
    end
    lp0 = '0; lp180 = '0;
  endtask

  task automatic cyc(input logic e, input logic [1:0] ce, input logic [1:0] ld,
                     input int n0, input int n1, input logic s);
    exp_t x;
    @(negedge clk);
    en = e; ch_en = ce; load = ld; sync = s;
    period_in = {W'(n1), W'(n0)};
    x.w = '0;
    for (int k = 0; k < C; k++) begin
      if (ld[k]) begin
        period_pat(k == 0 ? n0 : n1, npat[k], nlen[k]);
        pend[k] = 1'b1;
      end
      if (e && ce[k]) begin
        if (s) idx[k] = 0;
        if (idx[k] == 0 && pend[k]) begin
          pat[k] = npat[k]; len[k] = nlen[k]; pend[k] = 1'b0;
        end
        lp0[k] = pat[k][idx[k]];
        lp180[k] = !lp0[k];
        x.w[k] = idx[k] == 0;
        idx[k] = (idx[k] + 1) % len[k];
      end
    end
    x.p0 = lp0; x.p180 = lp180;
    q.push_back(x);
  endtask

  task automatic idle(input int n, input logic [1:0] ce);
    for (int i = 0; i < n; i++) cyc(1'b1, ce, 2'b00, 0, 0, 1'b0);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      checks++;
      if ({tick_phase0, tick_phase180, wrap} !== {e.p0, e.p180, e.w}) begin
        errors++;
        $display("FAIL outputs t=%0t p0/p180/wrap got %b/%b/%b want %b/%b/%b",
                 $time, tick_phase0, tick_phase180, wrap, e.p0, e.p180, e.w);
      end
    end
  end

  task automatic check_zero(input string name);
    checks++;
    if ({tick_phase0, tick_phase180, wrap} !== '0) begin
      errors++;
      $display("FAIL %s got %b/%b/%b want all 0", name, tick_phase0, tick_phase180, wrap);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #2 check_zero("reset_state");
    @(negedge clk) rst = 1'b1;
    cyc(1'b0, 2'b11, 2'b00, 0, 0, 1'b0);
    cyc(1'b0, 2'b11, 2'b00, 0, 0, 1'b1);
    idle(3, 2'b11);
    // N=5 on channel 0 while channel 1 keeps N=0
    cyc(1'b1, 2'b11, 2'b01, 5, 0, 1'b0);
    idle(14, 2'b11);
    // reload N=9 with count at 3
    while (idx[0] != 3) idle(1, 2'b11);
    cyc(1'b1, 2'b11, 2'b01, 9, 0, 1'b0);
    idle(25, 2'b11);
    // double load before boundary: only the last one applies
    while (idx[0] != 8) idle(1, 2'b11);
    cyc(1'b1, 2'b11, 2'b01, 7, 0, 1'b0);
    cyc(1'b1, 2'b11, 2'b01, 3, 0, 1'b0);
    idle(9, 2'b11);
    // load coinciding with the wrap takes effect at that wrap
    while (idx[0] != 0) idle(1, 2'b11);
    cyc(1'b1, 2'b11, 2'b01, 5, 0, 1'b0);
    idle(4, 2'b11);
    cyc(1'b1, 2'b11, 2'b10, 0, 7, 1'b0);
    idle(5, 2'b11);
    cyc(1'b1, 2'b11, 2'b00, 0, 0, 1'b1);
    idle(50, 2'b11);
    // freeze channel 1
    idle(4, 2'b01);
    idle(10, 2'b11);
    cyc(1'b0, 2'b11, 2'b00, 0, 0, 1'b1);
    cyc(1'b1, 2'b01, 2'b00, 0, 0, 1'b1);
    idle(3, 2'b11);
    // async reset between edges
    @(posedge clk);
    #3 rst = 1'b0;
    #1 check_zero("async_reset");
    model_reset();
    @(negedge clk) rst = 1'b1;
    idle(3, 2'b11);
    @(posedge clk);
    #3;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain got %0d entries want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
